// File: rtl/flt_pkg.sv
// Shared state encoding, default frame geometry and gray weights for the
// VRAM filter controller.
package flt_pkg;

  localparam int DEF_H_PIX = 640;
  localparam int DEF_V_PIX = 480;
  localparam int DEF_BURST = 16;

  localparam int GRAY_R = 77;
  localparam int GRAY_G = 150;
  localparam int GRAY_B = 29;

  typedef enum logic [2:0] {
    IDLE,
    RREQ,
    RDAT,
    WREQ,
    WDAT,
    DONE
  } flt_state_t;

endpackage

// File: rtl/flt_pixfilt.sv
// Combinational per-pixel channel filter. With FLT_GRAY_EN defined, COLOR=000
// produces a luma gray pixel instead of black.
module flt_pixfilt
  import flt_pkg::*;
(
  input  logic [31:0] pix,
  input  logic [2:0]  color,
  output logic [31:0] pix_flt
);

`ifdef FLT_GRAY_EN
  logic [7:0] gray_y;

  // Weights sum to 256, so the 16-bit sum cannot overflow.
  assign gray_y = 8'((16'(GRAY_R) * {8'h00, pix[23:16]}
                    + 16'(GRAY_G) * {8'h00, pix[15:8]}
                    + 16'(GRAY_B) * {8'h00, pix[7:0]}) >> 8);
`endif

  always_comb begin
    pix_flt = {pix[31:24],
               color[2] ? pix[23:16] : 8'h00,
               color[1] ? pix[15:8]  : 8'h00,
               color[0] ? pix[7:0]   : 8'h00};
`ifdef FLT_GRAY_EN
    if (color == 3'b000) begin
      pix_flt[23:0] = {3{gray_y}};
    end
`endif
  end

endmodule

// File: rtl/flt_vramctrl.sv
// Burst-based VRAM frame filter: reads a burst, filters it into a local buffer,
// writes it back out. Optional FLT_GRAY_EN selects gray output for COLOR=000.
module flt_vramctrl
  import flt_pkg::*;
#(
  parameter int H_PIX = DEF_H_PIX,
  parameter int V_PIX = DEF_V_PIX,
  parameter int BURST = DEF_BURST
) (
  input  logic        CLK,
  input  logic        ARST,
  input  logic        FLTRG_RSTS,
  input  logic        FLTRG_START,
  input  logic [31:0] FLTRG_VRAMSRC,
  input  logic [31:0] FLTRG_VRAMFRM,
  input  logic [2:0]  FLTRG_COLOR,
  output logic        FLTVC_BUSY,
  output logic        FLTVC_INT,
  output logic        RDREQ,
  output logic [31:0] RDADR,
  input  logic        RDACK,
  input  logic        RDVALID,
  input  logic [31:0] RDDATA,
  output logic        WRREQ,
  output logic [31:0] WRADR,
  input  logic        WRACK,
  output logic        WRVALID,
  output logic [31:0] WRDATA,
  input  logic        WRREADY
);

  localparam int N_BURSTS = H_PIX * V_PIX / BURST;
  localparam int BCNT_W   = (N_BURSTS > 1) ? $clog2(N_BURSTS) : 1;
  localparam int IDX_W    = (BURST > 1) ? $clog2(BURST) : 1;

  flt_state_t        state, state_next;
  logic [BCNT_W-1:0] burst_cnt;
  logic [IDX_W-1:0]  beat_idx;
  logic [31:0]       src_adr, frm_adr;
  logic [2:0]        color;
  logic [31:0]       beat_buf [BURST];
  logic [31:0]       pix_flt;
  logic [31:0]       burst_off;
  logic              idx_last, burst_last, soft_rst;

  assign soft_rst   = ARST || FLTRG_RSTS;
  assign idx_last   = (beat_idx == IDX_W'(BURST - 1));
  assign burst_last = (burst_cnt == BCNT_W'(N_BURSTS - 1));
  assign burst_off  = 32'(burst_cnt) * 32'(BURST * 4);

  flt_pixfilt u_pixfilt (
    .pix     (RDDATA),
    .color   (color),
    .pix_flt (pix_flt)
  );

  always_ff @(posedge CLK) begin
    if (soft_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frame registers are captured only on an accepted start, so they stay
  // frozen for the whole frame regardless of later register writes.
  always_ff @(posedge CLK) begin
    if (soft_rst) begin
      burst_cnt <= '0;
      beat_idx  <= '0;
      src_adr   <= '0;
      frm_adr   <= '0;
      color     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (FLTRG_START) begin
            burst_cnt <= '0;
            beat_idx  <= '0;
            src_adr   <= FLTRG_VRAMSRC;
            frm_adr   <= FLTRG_VRAMFRM;
            color     <= FLTRG_COLOR;
          end
        end
        RDAT: begin
          if (RDVALID) begin
            beat_idx <= idx_last ? '0 : beat_idx + 1'b1;
          end
        end
        WDAT: begin
          if (WRREADY) begin
            beat_idx <= idx_last ? '0 : beat_idx + 1'b1;
            if (idx_last && !burst_last) begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (state == RDAT && RDVALID) begin
      beat_buf[beat_idx] <= pix_flt;
    end
  end

  // Bus outputs are zero outside their own state, so reset and IDLE leave
  // every address and data port at 0.
  always_comb begin
    state_next = state;
    FLTVC_BUSY = (state != IDLE);
    FLTVC_INT  = 1'b0;
    RDREQ      = 1'b0;
    RDADR      = '0;
    WRREQ      = 1'b0;
    WRADR      = '0;
    WRVALID    = 1'b0;
    WRDATA     = '0;
    case (state)
      IDLE: begin
        if (FLTRG_START) state_next = RREQ;
      end
      RREQ: begin
        RDREQ = 1'b1;
        RDADR = src_adr + burst_off;
        if (RDACK) state_next = RDAT;
      end
      RDAT: begin
        if (RDVALID && idx_last) state_next = WREQ;
      end
      WREQ: begin
        WRREQ = 1'b1;
        WRADR = frm_adr + burst_off;
        if (WRACK) state_next = WDAT;
      end
      WDAT: begin
        WRVALID = 1'b1;
        WRDATA  = beat_buf[beat_idx];
        if (WRREADY && idx_last) state_next = burst_last ? DONE : RREQ;
      end
      DONE: begin
        FLTVC_INT  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
